// File: rtl/commit_ctrl.sv
// commit_ctrl: retire sequencer between the ROB head and the register file.
// Retires one completed head per cycle; a mispredict starts a timed rollback.
module commit_ctrl #(
  parameter int ROB_BIT   = 4,
  parameter int RB_CYCLES = 2,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               stall_in,
  input  logic               head_vld,
  input  logic               head_done,
  input  logic [ROB_BIT-1:0] head_idx,
  input  logic               head_has_rd,
  input  logic [4:0]         head_rd,
  input  logic [31:0]        head_val,
  input  logic               head_mispred,
  input  logic [31:0]        head_tgt,
  output logic               head_pop,
  output logic               rf_wr_ena,
  output logic [4:0]         rf_wr_rd,
  output logic [31:0]        rf_wr_val,
  output logic [ROB_BIT-1:0] rf_wr_idx,
  output logic               reg_rb,
  output logic               redirect_ena,
  output logic [31:0]        redirect_pc,
  output logic               busy_rb,
  output logic [CNT_W-1:0]   commit_cnt
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [3:0] RB_LOAD = 4'(RB_CYCLES - 1);

  logic [0:0] state;
  logic [3:0] flush_cnt;

  // Tag 0 means "no producer", so a head carrying it is never consumed.
  assign head_pop = (state == RUN) & !rst & rdy & !stall_in &
                    head_vld & head_done & (head_idx != '0);

  assign busy_rb = (state == FLUSH);
  assign reg_rb  = busy_rb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      flush_cnt    <= 4'd0;
      rf_wr_ena    <= 1'b0;
      rf_wr_rd     <= 5'd0;
      rf_wr_val    <= 32'd0;
      rf_wr_idx    <= '0;
      redirect_ena <= 1'b0;
      redirect_pc  <= 32'd0;
      commit_cnt   <= '0;
    end else if (rdy) begin
      rf_wr_ena    <= 1'b0;
      redirect_ena <= 1'b0;
      if (head_pop) begin
        rf_wr_ena  <= head_has_rd & (head_rd != 5'd0);
        rf_wr_rd   <= head_rd;
        rf_wr_val  <= head_val;
        rf_wr_idx  <= head_idx;
        commit_cnt <= commit_cnt + CNT_W'(1);
        if (head_mispred) begin
          state        <= FLUSH;
          flush_cnt    <= RB_LOAD;
          redirect_ena <= 1'b1;
          redirect_pc  <= head_tgt;
        end
      end else if (state == FLUSH) begin
        // Leaving FLUSH on the zero count keeps reg_rb high RB_CYCLES cycles.
        if (flush_cnt == 4'd0) begin
          state <= RUN;
        end else begin
          flush_cnt <= flush_cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed scenarios plus random traffic for commit_ctrl,
// checked against a cycle-level reference model of the retire rules.
module tb_commit_ctrl;

  localparam int ROB_BIT   = 4;
  localparam int RB_CYCLES = 2;
  localparam int CNT_W     = 4;
  localparam int VW = 1 + 5 + 32 + ROB_BIT + 1 + 1 + 32 + 1 + CNT_W;

  logic clk = 1'b0;
  logic rst, rdy, stall_in;
  logic head_vld, head_done, head_has_rd, head_mispred;
  logic [ROB_BIT-1:0] head_idx;
  logic [4:0] head_rd;
  logic [31:0] head_val, head_tgt;

  logic head_pop, rf_wr_ena, reg_rb, redirect_ena, busy_rb;
  logic [4:0] rf_wr_rd;
  logic [31:0] rf_wr_val, redirect_pc;
  logic [ROB_BIT-1:0] rf_wr_idx;
  logic [CNT_W-1:0] commit_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: remaining rollback cycles plus last registered outputs.
  int m_rb_left = 0;
  int m_cnt = 0;
  logic m_wr = 1'b0;
  logic m_redir = 1'b0;
  logic [4:0] m_rd = 5'd0;
  logic [31:0] m_val = 32'd0;
  logic [31:0] m_pc = 32'd0;
  logic [ROB_BIT-1:0] m_idx = '0;

  wire [VW-1:0] dut_vec = {rf_wr_ena, rf_wr_rd, rf_wr_val, rf_wr_idx,
                           reg_rb, redirect_ena, redirect_pc, busy_rb,
                           commit_cnt};

  commit_ctrl #(
    .ROB_BIT(ROB_BIT), .RB_CYCLES(RB_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_in(stall_in),
    .head_vld(head_vld), .head_done(head_done), .head_idx(head_idx),
    .head_has_rd(head_has_rd), .head_rd(head_rd), .head_val(head_val),
    .head_mispred(head_mispred), .head_tgt(head_tgt),
    .head_pop(head_pop), .rf_wr_ena(rf_wr_ena), .rf_wr_rd(rf_wr_rd),
    .rf_wr_val(rf_wr_val), .rf_wr_idx(rf_wr_idx), .reg_rb(reg_rb),
    .redirect_ena(redirect_ena), .redirect_pc(redirect_pc),
    .busy_rb(busy_rb), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_pop();
    return !rst && rdy && !stall_in && head_vld && head_done &&
           (head_idx != '0) && (m_rb_left == 0);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic rb;
    rb = (m_rb_left > 0);
    return {m_wr, m_rd, m_val, m_idx, rb, m_redir, m_pc, rb,
            CNT_W'(m_cnt)};
  endfunction

  // Advance one clock; the model applies the retire rules at the same edge.
  task automatic tick();
    logic p;
    p = exp_pop();
    @(posedge clk);
    if (rst) begin
      m_rb_left = 0; m_cnt = 0; m_wr = 1'b0; m_redir = 1'b0;
      m_rd = 5'd0; m_val = 32'd0; m_pc = 32'd0; m_idx = '0;
    end else if (rdy) begin
      m_wr = 1'b0;
      m_redir = 1'b0;
      if (m_rb_left > 0) m_rb_left--;
      if (p) begin
        m_wr  = head_has_rd && (head_rd != 5'd0);
        m_rd  = head_rd;
        m_val = head_val;
        m_idx = head_idx;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (head_mispred) begin
          m_rb_left = RB_CYCLES;
          m_redir = 1'b1;
          m_pc = head_tgt;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_head(input logic v, input logic d,
                          input logic [ROB_BIT-1:0] idx,
                          input logic hr, input logic [4:0] rd,
                          input logic [31:0] val, input logic mis,
                          input logic [31:0] tgt);
    head_vld = v; head_done = d; head_idx = idx; head_has_rd = hr;
    head_rd = rd; head_val = val; head_mispred = mis; head_tgt = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; stall_in = 1'b0;
    set_head(1, 1, 4'd1, 1, 5'd5, 32'h55, 0, 32'h0);
    repeat (2) tick();
    #1;
    total++;
    if (head_pop !== 1'b0) begin
      bad++; $display("FAIL reset_pop got=%b exp=0", head_pop);
    end
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL reset_outs got=%h exp=0", dut_vec);
    end
    total++;
    if (commit_cnt !== '0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", commit_cnt);
    end
    rst = 1'b0;
    set_head(0, 0, 4'd0, 0, 5'd0, 32'h0, 0, 32'h0);
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      set_head(1, 1, 4'(i + 1), 1, 5'(5 + i), 32'(32'h11 * (i + 1)), 0, 0);
      #1;
      total++;
      if (head_pop !== 1'b1) begin
        bad++; $display("FAIL stream_pop%0d got=%b exp=1", i, head_pop);
      end
      tick();
      total++;
      if (rf_wr_ena !== 1'b1 || rf_wr_rd !== 5'(5 + i) ||
          rf_wr_val !== 32'(32'h11 * (i + 1)) || rf_wr_idx !== 4'(i + 1)) begin
        bad++;
        $display("FAIL stream_wr%0d got=%b/%0d/%h/%0d exp=1/%0d/%h/%0d", i,
                 rf_wr_ena, rf_wr_rd, rf_wr_val, rf_wr_idx,
                 5 + i, 32'h11 * (i + 1), i + 1);
      end
    end
    set_head(0, 0, 4'd0, 0, 5'd0, 32'h0, 0, 32'h0);
    #1;
    tick();
    total++;
    if (rf_wr_ena !== 1'b0 || rf_wr_rd !== 5'd7 || commit_cnt !== 4'd3) begin
      bad++;
      $display("FAIL stream_end got=%b/%0d/%0d exp=0/7/3",
               rf_wr_ena, rf_wr_rd, commit_cnt);
    end
  endtask

  task automatic test_x0();
    set_head(1, 1, 4'd8, 1, 5'd0, 32'hAA, 0, 0);
    #1;
    total++;
    if (head_pop !== 1'b1) begin
      bad++; $display("FAIL x0_pop got=%b exp=1", head_pop);
    end
    tick();
    total++;
    if (rf_wr_ena !== 1'b0 || rf_wr_idx !== 4'd8) begin
      bad++; $display("FAIL x0_wr got=%b/%0d exp=0/8", rf_wr_ena, rf_wr_idx);
    end
    set_head(1, 1, 4'd9, 0, 5'd3, 32'hBB, 0, 0);
    #1;
    total++;
    if (head_pop !== 1'b1) begin
      bad++; $display("FAIL nord_pop got=%b exp=1", head_pop);
    end
    tick();
    total++;
    if (rf_wr_ena !== 1'b0 || commit_cnt !== 4'd5) begin
      bad++;
      $display("FAIL nord_wr got=%b/%0d exp=0/5", rf_wr_ena, commit_cnt);
    end
  endtask

  task automatic test_mispred();
    int n_rb;
    int guard;
    set_head(1, 1, 4'd4, 1, 5'd9, 32'h40, 1, 32'h1000);
    #1;
    total++;
    if (head_pop !== 1'b1) begin
      bad++; $display("FAIL mis_pop got=%b exp=1", head_pop);
    end
    tick();
    total++;
    if (rf_wr_ena !== 1'b1 || rf_wr_rd !== 5'd9 || rf_wr_val !== 32'h40 ||
        redirect_ena !== 1'b1 || redirect_pc !== 32'h1000 ||
        reg_rb !== 1'b1 || busy_rb !== 1'b1) begin
      bad++;
      $display("FAIL mis_first got=%h exp=%h", dut_vec, exp_vec());
    end
    n_rb = reg_rb ? 1 : 0;
    guard = 0;
    set_head(1, 1, 4'd5, 1, 5'd10, 32'h50, 0, 0);
    while (busy_rb === 1'b1 && guard < 10) begin
      #1;
      total++;
      if (head_pop !== 1'b0) begin
        bad++; $display("FAIL mis_nopop got=%b exp=0", head_pop);
      end
      tick();
      total++;
      if (dut_vec !== exp_vec() || redirect_ena !== 1'b0 ||
          rf_wr_ena !== 1'b0) begin
        bad++; $display("FAIL mis_flush got=%h exp=%h", dut_vec, exp_vec());
      end
      if (reg_rb === 1'b1) n_rb++;
      guard++;
    end
    total++;
    if (n_rb != RB_CYCLES) begin
      bad++; $display("FAIL mis_rb_len got=%0d exp=%0d", n_rb, RB_CYCLES);
    end
    #1;
    total++;
    if (head_pop !== 1'b1) begin
      bad++; $display("FAIL mis_resume got=%b exp=1", head_pop);
    end
    tick();
    total++;
    if (rf_wr_ena !== 1'b1 || rf_wr_rd !== 5'd10 || commit_cnt !== 4'd7) begin
      bad++;
      $display("FAIL mis_after got=%b/%0d/%0d exp=1/10/7",
               rf_wr_ena, rf_wr_rd, commit_cnt);
    end
  endtask

  task automatic test_freeze();
    int n_rb;
    int k;
    set_head(1, 1, 4'd6, 1, 5'd11, 32'h60, 1, 32'h2000);
    #1;
    tick();
    n_rb = reg_rb ? 1 : 0;
    k = 0;
    set_head(1, 1, 4'd7, 1, 5'd12, 32'h70, 0, 0);
    while (busy_rb === 1'b1 && k < 12) begin
      rdy = !(k >= 1 && k <= 3);
      #1;
      total++;
      if (head_pop !== 1'b0) begin
        bad++; $display("FAIL frz_nopop k=%0d got=%b exp=0", k, head_pop);
      end
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL frz_vec k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (reg_rb === 1'b1) n_rb++;
      k++;
    end
    rdy = 1'b1;
    total++;
    if (n_rb != RB_CYCLES + 3) begin
      bad++; $display("FAIL frz_rb_len got=%0d exp=%0d", n_rb, RB_CYCLES + 3);
    end
    rdy = 1'b0;
    #1;
    total++;
    if (head_pop !== 1'b0) begin
      bad++; $display("FAIL frz_run_pop got=%b exp=0", head_pop);
    end
    tick();
    rdy = 1'b1;
    stall_in = 1'b1;
    #1;
    total++;
    if (head_pop !== 1'b0) begin
      bad++; $display("FAIL stall_pop got=%b exp=0", head_pop);
    end
    tick();
    total++;
    if (commit_cnt !== 4'd8 || rf_wr_ena !== 1'b0) begin
      bad++;
      $display("FAIL stall_cnt got=%0d/%b exp=8/0", commit_cnt, rf_wr_ena);
    end
    stall_in = 1'b0;
    set_head(0, 0, 4'd0, 0, 5'd0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_rst_flush();
    set_head(1, 1, 4'd3, 1, 5'd4, 32'h30, 1, 32'h3000);
    #1;
    tick();
    total++;
    if (reg_rb !== 1'b1) begin
      bad++; $display("FAIL rstf_enter got=%b exp=1", reg_rb);
    end
    rst = 1'b1;
    tick();
    total++;
    if (reg_rb !== 1'b0 || busy_rb !== 1'b0 || commit_cnt !== '0 ||
        dut_vec !== exp_vec()) begin
      bad++; $display("FAIL rstf_clear got=%h exp=%h", dut_vec, exp_vec());
    end
    rst = 1'b0;
    set_head(1, 1, 4'd2, 1, 5'd2, 32'h20, 0, 0);
    #1;
    total++;
    if (head_pop !== 1'b1) begin
      bad++; $display("FAIL rstf_run got=%b exp=1", head_pop);
    end
    tick();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_head(1, 1, 4'((i % 15) + 1), 1, 5'(i), 32'(i), 0, 0);
      #1;
      tick();
      if (i == 14) begin
        total++;
        if (commit_cnt !== 4'd15) begin
          bad++; $display("FAIL wrap_15 got=%0d exp=15", commit_cnt);
        end
      end
    end
    total++;
    if (commit_cnt !== 4'd0) begin
      bad++; $display("FAIL wrap_0 got=%0d exp=0", commit_cnt);
    end
    set_head(0, 0, 4'd0, 0, 5'd0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom % 60) == 0;
      rdy = ($urandom % 8) != 0;
      stall_in = ($urandom % 6) == 0;
      set_head(($urandom % 5) != 0, ($urandom % 4) != 0,
               4'($urandom % 16), 1'($urandom % 2), 5'($urandom),
               $urandom, ($urandom % 8) == 0, $urandom);
      #1;
      total++;
      if (head_pop !== exp_pop()) begin
        bad++; $display("FAIL rnd_pop c=%0d got=%b exp=%b", c, head_pop, exp_pop());
      end
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL rnd_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
    end
    rst = 1'b0; rdy = 1'b1; stall_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall_in = 1'b0;
    set_head(0, 0, 4'd0, 0, 5'd0, 32'h0, 0, 32'h0);
    test_reset();
    test_stream();
    test_x0();
    test_mispred();
    test_freeze();
    test_rst_flush();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
